// File: rtl/i_fetch.sv
// i_fetch: instruction fetch stage with loadable instruction memory and IF/ID register.
// Define I_FETCH_REDIRECT_COUNT_EN to add the taken-redirect counter on o_redirect_count.
module i_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_stall,
    input  logic                  i_branch,
    input  logic [DATA_WIDTH-1:0] i_pcbranch,
    input  logic                  i_jump,
    input  logic [DATA_WIDTH-1:0] i_pcjump,
    input  logic                  i_halt,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_instruccion,
    output logic [DATA_WIDTH-1:0] o_currentpc,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic                  o_halted,
    output logic [DATA_WIDTH-1:0] o_redirect_count
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] pc_q, pc_d, instr_q, instr_d, cpc_q, cpc_d, pc_inc, fetch_word;
    logic                  halted_q, halted_d, halt_now, advance, redirect, flush;
    logic                  unused_wr_addr;

    assign unused_wr_addr = ^i_wr_addr[DATA_WIDTH-1:AW];

    // Halt outranks stall and redirect, so it is excluded from the advance condition.
    always_comb begin
        pc_inc     = pc_q + DATA_WIDTH'(1);
        fetch_word = mem[pc_q[AW-1:0]];
        halt_now   = i_enable && i_halt && !halted_q;
        advance    = i_enable && !i_stall && !halted_q && !i_halt;
        redirect   = advance && (i_jump || i_branch);
        flush      = halt_now || redirect;
        pc_d       = !advance ? pc_q : i_jump ? i_pcjump : i_branch ? i_pcbranch : pc_inc;
        instr_d    = flush ? '0 : advance ? fetch_word : instr_q;
        cpc_d      = flush ? '0 : advance ? pc_inc : cpc_q;
        halted_d   = halted_q || halt_now;
    end

    // Memory has no reset so a program survives i_reset; writes during reset are dropped.
    always_ff @(posedge i_clock) begin
        if (i_wr_en && !i_reset) mem[i_wr_addr[AW-1:0]] <= i_wr_data;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pc_q     <= '0;
            instr_q  <= '0;
            cpc_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            cpc_q    <= cpc_d;
            halted_q <= halted_d;
        end
    end

    assign o_instruccion = instr_q;
    assign o_currentpc   = cpc_q;
    assign o_pc          = pc_q;
    assign o_halted      = halted_q;

`ifdef I_FETCH_REDIRECT_COUNT_EN
    logic [DATA_WIDTH-1:0] count_q, count_d;

    always_comb count_d = redirect ? count_q + DATA_WIDTH'(1) : count_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) count_q <= '0;
        else         count_q <= count_d;
    end

    assign o_redirect_count = count_q;
`else
    logic unused_redirect;

    assign unused_redirect  = redirect;
    assign o_redirect_count = '0;
`endif
endmodule

// File: tb/tb_i_fetch.sv
// tb_i_fetch: directed self-checking bench for i_fetch (default parameters).
module tb_i_fetch;
    logic        i_clock = 1'b0;
    logic        i_reset, i_enable, i_stall, i_branch, i_jump, i_halt, i_wr_en;
    logic [31:0] i_pcbranch, i_pcjump, i_wr_addr, i_wr_data;
    logic [31:0] o_instruccion, o_currentpc, o_pc, o_redirect_count;
    logic        o_halted;
    int          errors = 0;
    int          checks = 0;

    i_fetch dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_stall(i_stall),
        .i_branch(i_branch), .i_pcbranch(i_pcbranch), .i_jump(i_jump), .i_pcjump(i_pcjump),
        .i_halt(i_halt), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .o_instruccion(o_instruccion), .o_currentpc(o_currentpc), .o_pc(o_pc),
        .o_halted(o_halted), .o_redirect_count(o_redirect_count)
    );

    always #5 i_clock = ~i_clock;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick;
        @(negedge i_clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int n);
`ifdef I_FETCH_REDIRECT_COUNT_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    task automatic state(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] cpc, input logic h, input int n);
        chk({tag, ".pc"}, o_pc, pc);
        chk({tag, ".instr"}, o_instruccion, ins);
        chk({tag, ".cpc"}, o_currentpc, cpc);
        chk({tag, ".halted"}, {31'b0, o_halted}, {31'b0, h});
        chk({tag, ".count"}, o_redirect_count, cnt(n));
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
        tick();
        i_wr_en = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1; i_enable = 1'b0; i_stall = 1'b0; i_branch = 1'b0; i_jump = 1'b0;
        i_halt = 1'b0; i_wr_en = 1'b0; i_pcbranch = '0; i_pcjump = '0; i_wr_addr = '0;
        i_wr_data = '0;
        tick();
        state("reset", 0, 0, 0, 1'b0, 0);
        i_reset = 1'b0;
        load(0, 32'h11); load(1, 32'h22); load(2, 32'h33); load(3, 32'h44);
        load(9, 32'h99); load(10, 32'h100); load(16, 32'hAA);
        state("idle_load", 0, 0, 0, 1'b0, 0);

        i_enable = 1'b1;
        tick(); state("fetch0", 1, 32'h11, 1, 1'b0, 0);
        tick(); state("fetch1", 2, 32'h22, 2, 1'b0, 0);
        i_branch = 1'b1; i_pcbranch = 32'h10;
        tick(); state("branch", 32'h10, 0, 0, 1'b0, 1);
        i_branch = 1'b0;
        tick(); state("after_branch", 32'h11, 32'hAA, 32'h11, 1'b0, 1);
        i_jump = 1'b1; i_pcjump = 2;
        tick(); state("jump", 2, 0, 0, 1'b0, 2);
        i_jump = 1'b0;
        tick(); state("fetch2", 3, 32'h33, 3, 1'b0, 2);

        i_branch = 1'b1; i_pcbranch = 5; i_jump = 1'b1; i_pcjump = 9;
        tick(); state("jump_prio", 9, 0, 0, 1'b0, 3);
        i_branch = 1'b0; i_jump = 1'b0;
        tick(); state("fetch9", 10, 32'h99, 10, 1'b0, 3);
        i_branch = 1'b1; i_jump = 1'b1; i_stall = 1'b1;
        tick(); state("stall", 10, 32'h99, 10, 1'b0, 3);
        i_stall = 1'b0; i_branch = 1'b0; i_pcjump = 32'h30; i_enable = 1'b0;
        load(32'd259, 32'h333);
        state("disabled", 10, 32'h99, 10, 1'b0, 3);
        i_jump = 1'b0; i_enable = 1'b1;

        i_wr_en = 1'b1; i_wr_addr = 10; i_wr_data = 32'h200;
        tick(); state("wr_same_old", 11, 32'h100, 11, 1'b0, 3);
        i_wr_en = 1'b0; i_jump = 1'b1; i_pcjump = 10;
        tick(); state("jump10", 10, 0, 0, 1'b0, 4);
        i_jump = 1'b0;
        tick(); state("wr_same_new", 11, 32'h200, 11, 1'b0, 4);
        i_branch = 1'b1; i_pcbranch = 2;
        tick(); i_branch = 1'b0; i_jump = 1'b1; i_pcjump = 2;
        tick(); i_pcjump = 3;
        tick(); state("redirect7", 3, 0, 0, 1'b0, 7);
        i_jump = 1'b0;
        tick(); state("wrap_read", 4, 32'h333, 4, 1'b0, 7);

        i_halt = 1'b1; i_branch = 1'b1; i_pcbranch = 32'h20;
        tick(); state("halt", 4, 0, 0, 1'b1, 7);
        i_halt = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("halted_pc%0d", k), o_pc, 4);
            chk($sformatf("halted_flag%0d", k), {31'b0, o_halted}, 1);
        end
        state("halted_end", 4, 0, 0, 1'b1, 7);

        i_reset = 1'b1; i_wr_en = 1'b1; i_wr_addr = 0; i_wr_data = 32'hDEAD;
        tick(); state("reset_halted", 0, 0, 0, 1'b0, 0);
        i_reset = 1'b0; i_wr_en = 1'b0; i_branch = 1'b0;
        tick(); state("mem_intact", 1, 32'h11, 1, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i_fetch.md
I_FETCH -- requirements
Module: I_FETCH

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the width of the instruction word and PC.
REQ-002 The block SHALL have parameter MEM_DEPTH, default 256, the instruction memory depth in words (power of two).
REQ-003 The block SHALL have port i_clock  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port i_enable  input  1  run/step enable from the debug unit; 0 freezes all pipeline state.
REQ-006 The block SHALL have port i_stall  input  1  load-use bubble from the hazard unit; holds PC and IF/ID.
REQ-007 The block SHALL have port i_branch  input  1  taken-branch flag resolved in decode.
REQ-008 The block SHALL have port i_pcbranch  input  DATA_WIDTH  branch target (word address).
REQ-009 The block SHALL have port i_jump  input  1  jump/jr/jal flag resolved in decode.
REQ-010 The block SHALL have port i_pcjump  input  DATA_WIDTH  jump target (word address).
REQ-011 The block SHALL have port i_halt  input  1  halt instruction detected in decode.
REQ-012 The block SHALL have port i_wr_en  input  1  instruction-memory load strobe.
REQ-013 The block SHALL have port i_wr_addr  input  DATA_WIDTH  load word address; only the low log2(MEM_DEPTH) bits are used.
REQ-014 The block SHALL have port i_wr_data  input  DATA_WIDTH  load word.
REQ-015 The block SHALL have port o_instruccion  output  DATA_WIDTH  IF/ID instruction register.
REQ-016 The block SHALL have port o_currentpc  output  DATA_WIDTH  IF/ID PC+1 of o_instruccion.
REQ-017 The block SHALL have port o_pc  output  DATA_WIDTH  current fetch PC (debug).
REQ-018 The block SHALL have port o_halted  output  1  sticky halted flag.
REQ-019 The block SHALL have port o_redirect_count  output  DATA_WIDTH  count of taken redirects (see Configuration).

Function
REQ-020 Instruction memory SHALL be MEM_DEPTH words, written synchronously when i_wr_en=1, and read combinationally at index PC mod MEM_DEPTH.
REQ-021 A write and a read to the same address in the same cycle SHALL deliver the old word to IF/ID; the new word is visible from the next cycle.
REQ-022 An advance cycle is one with i_enable=1, i_stall=0, and o_halted=0.
REQ-023 On an advance cycle with i_jump=1, PC SHALL load i_pcjump, and IF/ID SHALL load instruction 0 (NOP) with currentpc 0 (flush).
REQ-024 On an advance cycle with i_jump=0 and i_branch=1, PC SHALL load i_pcbranch, and IF/ID SHALL be flushed as in REQ-023.
REQ-025 On an advance cycle with no redirect, PC SHALL load PC+1 (modulo 2^DATA_WIDTH), and IF/ID SHALL load mem[PC] and PC+1.
REQ-026 i_jump SHALL take priority over i_branch when both are asserted; there is no delay slot.
REQ-027 When i_stall=1 (and i_enable=1), PC and IF/ID SHALL hold, and i_branch/i_jump SHALL be ignored; decode re-evaluates after the bubble.
REQ-028 When i_halt=1 on a cycle with i_enable=1, o_halted SHALL be set at the next edge, and that edge SHALL load NOP into IF/ID while PC holds; i_halt SHALL take priority over stall and redirect.
REQ-029 While o_halted=1, PC, IF/ID and o_halted SHALL hold until reset; memory writes SHALL still be accepted.
REQ-030 When i_enable=0, PC, IF/ID and o_halted SHALL hold, and memory writes SHALL still be accepted.
REQ-031 The latency SHALL be one cycle: mem[PC] appears on o_instruccion one edge after an advance cycle.

Reset
REQ-032 At a rising edge with i_reset=1, the block SHALL set PC=0, o_instruccion=0, o_currentpc=0, o_halted=0, and o_redirect_count=0, regardless of any other input, including mid-redirect or mid-halt.
REQ-033 Reset SHALL NOT clear instruction memory contents, and a write strobed during the reset cycle SHALL be ignored.
REQ-034 o_pc SHALL be combinationally equal to PC, and therefore 0 after reset.

Configuration
REQ-035 With macro I_FETCH_REDIRECT_COUNT_EN defined, o_redirect_count SHALL increment (wrapping) on every advance cycle that applies REQ-023 or REQ-024.
REQ-036 Without I_FETCH_REDIRECT_COUNT_EN, o_redirect_count SHALL be tied to 0, and no counter flops SHALL be synthesized.

Verification
REQ-037 The bench SHALL cover: load mem[0..3]=0x11,0x22,0x33,0x44, release reset, i_enable=1 -> o_instruccion 0x11,0x22,0x33 with o_currentpc 1,2,3 on consecutive cycles.
REQ-038 The bench SHALL cover: at PC=2, i_branch=1 and i_pcbranch=0x10 -> next o_instruccion=0, PC=0x10, then o_instruccion=mem[0x10]; the counter reads 1 if the macro is defined.
REQ-039 The bench SHALL cover: i_branch=1 and i_jump=1 together with i_pcbranch=5 and i_pcjump=9 -> PC=9; with i_stall=1 added -> PC and IF/ID unchanged.
REQ-040 The bench SHALL cover: i_halt pulse at PC=4 -> o_halted=1 next edge, IF/ID=0, and PC stays at 4 for 10 further cycles despite i_branch=1.
REQ-041 The bench SHALL cover: i_wr_en to address PC in the same cycle as the read -> IF/ID gets the old word, and the next read gets the new word; an address of MEM_DEPTH+3 wraps to 3.
REQ-042 The bench SHALL cover: i_reset=1 while halted with the counter at 7 -> PC=0, o_halted=0, count=0, and memory contents intact.
